// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, owner
// encoding and the block/word geometry used to build fill addresses.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // 8 words per block -> 3-bit word index; 16 bytes per block -> 4 offset bits.
    localparam int WORD_IDX_W   = 3;
    localparam int BLOCK_OFFS_W = 4;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker. req[0] is the I-cache, req[1] the D-cache.
// A lone requester always wins; on a tie the side not granted last wins.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic       grant,
    output logic       grant_valid
);

    // Pick the winner from the request pattern and the previous grant.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        grant = OWN_I;
        case (req)
            2'b10:   grant = OWN_D;
            2'b11:   grant = ~last_grant;
            default: grant = OWN_I;
        endcase
    end

    assign grant_valid = en & (|req);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between the I-cache and D-cache miss controllers and the single
// main memory. Grants one requester at a time and sequences either an
// 8-word block fill or a single-word D-cache write onto the memory port.
//
// Build option: define MEM_ARB_PIPELINE_EN to issue the eight fill reads on
// consecutive cycles (up to MEM_LAT reads in flight). Without it, only one
// read is outstanding at a time and each new read is issued in the cycle
// the previous word returns.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int WORDS   = 8,
    parameter int MEM_LAT = 4
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     fill_data,
    output logic [WORD_IDX_W-1:0] fill_word,
    output logic                  i_fill_valid,
    output logic                  d_fill_valid,
    output logic                  i_done,
    output logic                  d_done,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_valid,
    output logic                  busy
);

    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(WORDS - 1);

    // In-flight read counter never exceeds the memory latency.
    localparam int IF_W = $clog2(MEM_LAT + 1);
`ifdef MEM_ARB_PIPELINE_EN
    localparam int MAX_OUT = MEM_LAT;
`else
    localparam int MAX_OUT = 1;
`endif
    localparam logic [IF_W-1:0] MAX_OUT_V = IF_W'(MAX_OUT);

    state_t                  r_state;
    state_t                  w_next_state;
    owner_t                  r_owner;
    owner_t                  r_last_grant;
    logic [WORD_IDX_W-1:0]   r_issue_cnt;
    logic                    r_issue_all;
    logic [WORD_IDX_W-1:0]   r_ret_cnt;
    logic [IF_W-1:0]         r_inflight;

    logic                    w_grant;
    logic                    w_grant_valid;
    logic                    w_rd_valid;
    logic                    w_issue;
    logic                    w_fill_last;
    logic [ADDR_W-1:0]       w_base;
    logic [ADDR_W-1:0]       w_fill_addr;

    // Byte offset within the block comes from the word counter, and write
    // addresses are word aligned, so these request bits carry no information.
    logic                    w_unused_addr_bits;
    assign w_unused_addr_bits = ^{i_addr[BLOCK_OFFS_W-1:0], d_addr[0]};

    mem_arb_rr u_rr (
        .req         ({d_req, i_req}),
        .last_grant  (r_last_grant),
        .en          (r_state == ST_IDLE),
        .grant       (w_grant),
        .grant_valid (w_grant_valid)
    );

    // The owner holds its address stable until done, so it is read live.
    assign w_base      = (r_owner == OWN_D) ? d_addr : i_addr;
    assign w_fill_addr = {w_base[ADDR_W-1:BLOCK_OFFS_W], r_issue_cnt, 1'b0};

    // A return only counts if we actually have a read outstanding; this
    // discards stale mem_valid pulses from reads issued before a reset.
    assign w_rd_valid  = (r_state == ST_FILL) && mem_valid && (r_inflight != '0);
    // A slot frees up in the same cycle a word returns.
    assign w_issue     = (r_state == ST_FILL) && !r_issue_all &&
                         ((r_inflight < MAX_OUT_V) || w_rd_valid);
    assign w_fill_last = w_rd_valid && (r_ret_cnt == LAST_WORD);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every
        // flop samples pre-edge values regardless of process ordering.
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Latch the winner of arbitration as owner and as round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= OWN_I;
            r_last_grant <= OWN_D;
        end else if (w_grant_valid) begin
            r_owner      <= owner_t'(w_grant);
            r_last_grant <= owner_t'(w_grant);
        end
    end

    // Issue / return / in-flight counters; held at zero outside FILL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_cnt <= '0;
            r_issue_all <= 1'b0;
            r_ret_cnt   <= '0;
            r_inflight  <= '0;
        end else if (r_state != ST_FILL) begin
            r_issue_cnt <= '0;
            r_issue_all <= 1'b0;
            r_ret_cnt   <= '0;
            r_inflight  <= '0;
        end else begin
            if (w_issue) begin
                if (r_issue_cnt == LAST_WORD) r_issue_all <= 1'b1;
                else                          r_issue_cnt <= r_issue_cnt + WORD_IDX_W'(1);
            end
            if (w_rd_valid) r_ret_cnt <= r_ret_cnt + WORD_IDX_W'(1);
            case ({w_issue, w_rd_valid})
                2'b10:   r_inflight <= r_inflight + IF_W'(1);
                2'b01:   r_inflight <= r_inflight - IF_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid)
                    w_next_state = (w_grant == OWN_D && d_wr) ? ST_WRITE : ST_FILL;
            end
            ST_FILL:  if (w_fill_last) w_next_state = ST_IDLE;
            ST_WRITE: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Output decode from state and the fill datapath.
    always_comb begin
        fill_data    = '0;
        fill_word    = '0;
        i_fill_valid = 1'b0;
        d_fill_valid = 1'b0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        mem_addr     = '0;
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_wdata    = '0;
        busy         = 1'b0;
        case (r_state)
            ST_FILL: begin
                busy       = 1'b1;
                mem_addr   = w_fill_addr;
                mem_enable = w_issue;
                if (w_rd_valid) begin
                    fill_data = mem_rdata;
                    fill_word = r_ret_cnt;
                end
                i_fill_valid = w_rd_valid  && (r_owner == OWN_I);
                d_fill_valid = w_rd_valid  && (r_owner == OWN_D);
                i_done       = w_fill_last && (r_owner == OWN_I);
                d_done       = w_fill_last && (r_owner == OWN_D);
            end
            ST_WRITE: begin
                busy       = 1'b1;
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = {d_addr[ADDR_W-1:1], 1'b0};
                mem_wdata  = d_wdata;
                d_done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a 4-cycle-latency memory model.
// Expected timing follows the build selected by MEM_ARB_PIPELINE_EN.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        i_fill_valid;
    logic        d_fill_valid;
    logic        i_done;
    logic        d_done;
    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    mem_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .d_req        (d_req),
        .d_wr         (d_wr),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .fill_data    (fill_data),
        .fill_word    (fill_word),
        .i_fill_valid (i_fill_valid),
        .d_fill_valid (d_fill_valid),
        .i_done       (i_done),
        .d_done       (d_done),
        .mem_addr     (mem_addr),
        .mem_enable   (mem_enable),
        .mem_wr       (mem_wr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_valid    (mem_valid),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: read enabled in cycle n returns in cycle n+4; data is
    // the address XOR a fixed pattern. Not reset, so stale reads survive.
    logic [3:0]  pv = '0;
    logic [15:0] pa [4];
    always @(posedge clk) begin
        pv    <= {pv[2:0], mem_enable & ~mem_wr};
        pa[0] <= mem_addr;
        pa[1] <= pa[0];
        pa[2] <= pa[1];
        pa[3] <= pa[2];
    end
    assign mem_valid = pv[3];
    assign mem_rdata = pv[3] ? (pa[3] ^ 16'h5A5A) : 16'hDEAD;

    function automatic int en_cyc(input int k);
`ifdef MEM_ARB_PIPELINE_EN
        return 1 + k;
`else
        return 1 + 4 * k;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered at the start of cycle 0 with the owner's request already high.
    // Leaves at the start of the cycle after done, optionally dropping req.
    task automatic run_fill(input bit is_d, input logic [15:0] addr, input bit drop,
                            input int raise_d_at, input string name);
        int          done_c;
        bit          exp_en;
        bit          exp_v;
        logic [15:0] exp_addr;
        logic [15:0] exp_data;
        logic [2:0]  exp_word;
        logic [6:0]  exp_ctrl;
        logic [6:0]  got_ctrl;
        done_c = en_cyc(7) + 4;
        for (int c = 0; c <= done_c; c++) begin
            if (c > 0) step();
            if (c == raise_d_at) d_req = 1'b1;
            @(negedge clk);
            exp_en   = 1'b0;
            exp_v    = 1'b0;
            exp_addr = '0;
            exp_word = '0;
            for (int k = 0; k < 8; k++) begin
                if (en_cyc(k) == c) begin
                    exp_en   = 1'b1;
                    exp_addr = {addr[15:4], 3'(k), 1'b0};
                end
                if (en_cyc(k) + 4 == c) begin
                    exp_v    = 1'b1;
                    exp_word = 3'(k);
                end
            end
            exp_data = {addr[15:4], exp_word, 1'b0} ^ 16'h5A5A;
            exp_ctrl = {exp_en, 1'b0, (c >= 1), exp_v && !is_d, exp_v && is_d,
                        (c == done_c) && !is_d, (c == done_c) && is_d};
            got_ctrl = {mem_enable, mem_wr, busy, i_fill_valid, d_fill_valid, i_done, d_done};
            checks++;
            if (got_ctrl !== exp_ctrl) begin
                failures++;
                $display("FAIL %s ctrl cycle=%0d got=%b exp=%b (en,wr,busy,ifv,dfv,idone,ddone)",
                         name, c, got_ctrl, exp_ctrl);
            end
            if (exp_en) begin
                checks++;
                if (mem_addr !== exp_addr) begin
                    failures++;
                    $display("FAIL %s mem_addr cycle=%0d got=%h exp=%h", name, c, mem_addr, exp_addr);
                end
            end
            if (exp_v) begin
                checks++;
                if ({fill_word, fill_data} !== {exp_word, exp_data}) begin
                    failures++;
                    $display("FAIL %s fill cycle=%0d got word=%0d data=%h exp word=%0d data=%h",
                             name, c, fill_word, fill_data, exp_word, exp_data);
                end
            end
        end
        step();
        if (drop) begin
            if (is_d) d_req = 1'b0;
            else      i_req = 1'b0;
        end
    endtask

    // Entered at the start of cycle 0 with d_req/d_wr high.
    task automatic run_write(input logic [15:0] addr, input logic [15:0] data,
                             input bit drop, input string name);
        logic [6:0] got_ctrl;
        logic [15:0] exp_addr;
        exp_addr = {addr[15:1], 1'b0};
        @(negedge clk);
        got_ctrl = {mem_enable, mem_wr, busy, i_fill_valid, d_fill_valid, i_done, d_done};
        checks++;
        if (got_ctrl !== 7'b0000000) begin
            failures++;
            $display("FAIL %s idle ctrl got=%b exp=0000000", name, got_ctrl);
        end
        step();
        @(negedge clk);
        got_ctrl = {mem_enable, mem_wr, busy, i_fill_valid, d_fill_valid, i_done, d_done};
        checks++;
        if (got_ctrl !== 7'b1110001) begin
            failures++;
            $display("FAIL %s write ctrl got=%b exp=1110001", name, got_ctrl);
        end
        checks++;
        if ({mem_addr, mem_wdata} !== {exp_addr, data}) begin
            failures++;
            $display("FAIL %s write addr/data got=%h/%h exp=%h/%h", name, mem_addr, mem_wdata,
                     exp_addr, data);
        end
        step();
        if (drop) d_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [57:0] got_all;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        got_all = {fill_data, fill_word, i_fill_valid, d_fill_valid, i_done, d_done,
                   mem_addr, mem_enable, mem_wr, mem_wdata, busy};
        checks++;
        if (got_all !== '0) begin
            failures++;
            $display("FAIL reset outputs got=%h exp=0", got_all);
        end
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_i_fill();
        i_addr = 16'h1234;
        i_req  = 1'b1;
        run_fill(1'b0, 16'h1234, 1'b1, -1, "i_fill");
    endtask

    task automatic test_d_write();
        d_addr  = 16'h00A5;
        d_wdata = 16'hBEEF;
        d_wr    = 1'b1;
        d_req   = 1'b1;
        run_write(16'h00A5, 16'hBEEF, 1'b1, "d_write");
    endtask

    task automatic test_busy_request();
        i_addr = 16'h1234;
        d_addr = 16'h8F00;
        d_wr   = 1'b0;
        i_req  = 1'b1;
        run_fill(1'b0, 16'h1234, 1'b1, 3, "busy_i");
        run_fill(1'b1, 16'h8F00, 1'b1, -1, "busy_d");
    endtask

    task automatic test_tie();
        step();
        rst_n = 1'b0;
        step();
        rst_n   = 1'b1;
        i_addr  = 16'h4000;
        d_addr  = 16'h0101;
        d_wdata = 16'h1111;
        d_wr    = 1'b1;
        i_req   = 1'b1;
        d_req   = 1'b1;
        run_fill(1'b0, 16'h4000, 1'b0, -1, "tie_i1");
        run_write(16'h0101, 16'h1111, 1'b0, "tie_d1");
        run_fill(1'b0, 16'h4000, 1'b1, -1, "tie_i2");
        run_write(16'h0101, 16'h1111, 1'b1, "tie_d2");
    endtask

    task automatic test_reset_mid_fill();
        logic [57:0] got_all;
        logic [5:0]  got_ctrl;
        i_addr = 16'h2468;
        i_req  = 1'b1;
        for (int c = 1; c <= 6; c++) step();
        rst_n = 1'b0;
        i_req = 1'b0;
        #1;
        got_all = {fill_data, fill_word, i_fill_valid, d_fill_valid, i_done, d_done,
                   mem_addr, mem_enable, mem_wr, mem_wdata, busy};
        checks++;
        if (got_all !== '0) begin
            failures++;
            $display("FAIL mid_reset outputs got=%h exp=0", got_all);
        end
        step();
        rst_n = 1'b1;
        for (int c = 7; c <= 12; c++) begin
            @(negedge clk);
            got_ctrl = {busy, i_fill_valid, d_fill_valid, i_done, d_done, mem_enable};
            checks++;
            if (got_ctrl !== 6'b000000) begin
                failures++;
                $display("FAIL stale_valid cycle=%0d got=%b exp=000000", c, got_ctrl);
            end
            step();
        end
        i_addr = 16'hFFF0;
        i_req  = 1'b1;
        run_fill(1'b0, 16'hFFF0, 1'b1, -1, "refill");
    endtask

    initial begin
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_wr    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        test_reset();
        test_i_fill();
        test_d_write();
        test_busy_request();
        test_tie();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
